aexm_fsl_link: RTL and testbench
================================

// Module: aexm_fsl_link
// PURPOSE
//  FSL link controller between core register file and external FSL channel.
//  Buffers core PUT data (from regf fsl_dat_o) in a TX FIFO and external data in an RX FIFO.
//  Returns GET data to regf fsl_dat_i; stalls the core on blocking PUT/GET.
//  Reports failure of non-blocking ops on core_fail_o (drives MSR carry).
// PARAMETERS
//  AW   2   log2 of FIFO depth; TX and RX each hold 2**AW entries (default 4)
// PORTS
//  gclk           in   1   system clock, all flops rising edge
//  grst           in   1   asynchronous reset, active-low
//  core_put_i     in   1   PUT request, held by core while core_stall_o=1
//  core_get_i     in   1   GET request, held by core while core_stall_o=1
//  core_blk_i     in   1   1=blocking op, 0=non-blocking (nput/nget)
//  core_ctl_i     in   1   PUT: control bit to send; GET: expected control bit
//  core_dat_i     in   32  PUT data (regf fsl_dat_o)
//  core_dat_o     out  32  GET data (regf fsl_dat_i)
//  core_stall_o   out  1   1=hold core (combined into gena low)
//  core_fail_o    out  1   1=last non-blocking op did not complete
//  core_ctlerr_o  out  1   1=last GET control bit mismatched
//  tx_dat_o       out  32  TX FIFO head data
//  tx_ctl_o       out  1   TX FIFO head control bit
//  tx_vld_o       out  1   TX FIFO non-empty
//  tx_rdy_i       in   1   external consumer ready
//  rx_dat_i       in   32  external data
//  rx_ctl_i       in   1   external control bit
//  rx_vld_i       in   1   external data valid
//  rx_rdy_o       out  1   RX FIFO not full
// BEHAVIOUR
//  Reset (grst=0, async): TX/RX pointers, counts, core_dat_o, core_fail_o, core_ctlerr_o = 0.
//   FIFO storage not cleared. tx_vld_o=0, rx_rdy_o=0, core_stall_o=0 while reset asserted.
//  FIFOs: AW-bit wrapping rd/wr pointers, (AW+1)-bit count; 33-bit entries {ctl,dat}.
//   full = count==2**AW; empty = count==0; both from registered count only.
//  External: TX pop on tx_vld_o&tx_rdy_i; RX push on rx_vld_i&rx_rdy_o.
//   Pushes and pops in one cycle on one FIFO are both taken; count unchanged.
//  Simultaneous core_put_i and core_get_i: illegal; behaviour undefined.
//  PUT: accepted when core_put_i & !tx_full -> push {core_ctl_i,core_dat_i}, core_fail_o<=0.
//   tx_full & core_blk_i -> core_stall_o=1 (combinational), retry each cycle.
//   tx_full & !core_blk_i -> no push, core_fail_o<=1, no stall.
//   Full evaluated before same-cycle external pop: PUT on full stalls or fails even if pop occurs.
//  GET: accepted when core_get_i & !rx_empty -> pop, core_dat_o<=head dat, core_fail_o<=0.
//   rx_empty & core_blk_i -> core_stall_o=1, retry each cycle.
//   rx_empty & !core_blk_i -> core_dat_o unchanged, core_fail_o<=1, no stall.
//   Empty evaluated before same-cycle RX push: no bypass.
//  Latency: core_dat_o/core_fail_o/core_ctlerr_o valid the cycle after acceptance; held until next op.
//   Core data to tx_vld_o: 1 cycle. rx_vld_i to GET-able: 1 cycle.
//  core_stall_o = (core_put_i&core_blk_i&tx_full) | (core_get_i&core_blk_i&rx_empty).
//  Reset mid-stall: stall drops, request lost; core restarts with reset.
// CONFIGURATION
//  AEXM_FSL_CTLCHK_EN defined: accepted GET sets core_ctlerr_o <= (head ctl != core_ctl_i);
//   data still returned and popped. Failed non-blocking GET leaves core_ctlerr_o unchanged.
//  Not defined: core_ctlerr_o tied 0; RX ctl bit still stored (tx_ctl_o path unaffected).
// TESTING
//  Reset, then blocking PUT 0x11223344 ctl=1, tx_rdy_i=0 -> next cycle tx_vld_o=1, tx_dat_o=0x11223344, tx_ctl_o=1.
//  4 blocking PUTs, tx_rdy_i=0, 5th PUT -> core_stall_o=1; tx_rdy_i=1 one cycle -> stall drops next cycle, 5th accepted.
//  Non-blocking GET on empty RX -> no stall, core_fail_o=1, core_dat_o unchanged.
//  rx_vld_i with 0xCAFEF00D ctl=0, blocking GET ctl=0 -> core_dat_o=0xCAFEF00D, core_fail_o=0, core_ctlerr_o=0.
//  AEXM_FSL_CTLCHK_EN: RX ctl=1, GET expecting ctl=0 -> core_ctlerr_o=1, data popped; without macro core_ctlerr_o=0.
//  Blocking GET stalled on empty, grst pulsed low -> core_stall_o=0, counts 0, rx_rdy_o=1 after release.

Source files
------------

// File: rtl/aexm_fsl_link_if.sv
// Signal bundle for the FSL link: core PUT/GET request/response side and the external
// TX/RX channel. The link itself connects through the slave modport.
interface aexm_fsl_link_if;
    // Core side
    logic        core_put_i;
    logic        core_get_i;
    logic        core_blk_i;
    logic        core_ctl_i;
    logic [31:0] core_dat_i;
    logic [31:0] core_dat_o;
    logic        core_stall_o;
    logic        core_fail_o;
    logic        core_ctlerr_o;

    // External FSL channel
    logic [31:0] tx_dat_o;
    logic        tx_ctl_o;
    logic        tx_vld_o;
    logic        tx_rdy_i;
    logic [31:0] rx_dat_i;
    logic        rx_ctl_i;
    logic        rx_vld_i;
    logic        rx_rdy_o;

    modport slave (
        input  core_put_i, core_get_i, core_blk_i, core_ctl_i, core_dat_i,
        input  tx_rdy_i, rx_dat_i, rx_ctl_i, rx_vld_i,
        output core_dat_o, core_stall_o, core_fail_o, core_ctlerr_o,
        output tx_dat_o, tx_ctl_o, tx_vld_o, rx_rdy_o
    );

    modport master (
        output core_put_i, core_get_i, core_blk_i, core_ctl_i, core_dat_i,
        output tx_rdy_i, rx_dat_i, rx_ctl_i, rx_vld_i,
        input  core_dat_o, core_stall_o, core_fail_o, core_ctlerr_o,
        input  tx_dat_o, tx_ctl_o, tx_vld_o, rx_rdy_o
    );
endinterface

// File: rtl/aexm_fsl_link.sv
// FSL link controller: TX/RX FIFOs between the core register file and an FSL channel.
// Define AEXM_FSL_CTLCHK_EN to compare the RX control bit against the GET's expected bit.
module aexm_fsl_link #(
    parameter int unsigned AW = 2
) (
    input logic            gclk,
    input logic            grst,
    aexm_fsl_link_if.slave fsl
);

    localparam int unsigned Depth   = 1 << AW;
    localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);
    localparam logic [AW:0] CntOne  = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    // ------------------------------------------------------------------
    // TX FIFO (core -> external)
    // ------------------------------------------------------------------
    logic [32:0]   tx_mem [Depth];
    logic [AW-1:0] tx_wr_q;
    logic [AW-1:0] tx_rd_q;
    logic [AW:0]   tx_cnt_q;
    logic [AW:0]   tx_cnt_d;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;

    assign tx_full  = (tx_cnt_q == FullCnt);
    assign tx_empty = (tx_cnt_q == '0);
    // Full comes from the registered count, so a same-cycle external pop cannot admit a PUT.
    assign tx_push  = fsl.core_put_i & ~tx_full;
    assign tx_pop   = ~tx_empty & fsl.tx_rdy_i;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CntOne;
            2'b01:   tx_cnt_d = tx_cnt_q - CntOne;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            if (tx_push) begin
                tx_wr_q <= tx_wr_q + PtrOne;
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + PtrOne;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= {fsl.core_ctl_i, fsl.core_dat_i};
        end
    end

    assign fsl.tx_dat_o = tx_mem[tx_rd_q][31:0];
    assign fsl.tx_ctl_o = tx_mem[tx_rd_q][32];
    assign fsl.tx_vld_o = ~tx_empty & grst;

    // ------------------------------------------------------------------
    // RX FIFO (external -> core)
    // ------------------------------------------------------------------
    logic [32:0]   rx_mem [Depth];
    logic [AW-1:0] rx_wr_q;
    logic [AW-1:0] rx_rd_q;
    logic [AW:0]   rx_cnt_q;
    logic [AW:0]   rx_cnt_d;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_rdy;
    logic          rx_push;
    logic          rx_pop;
    logic [32:0]   rx_head;

    assign rx_full  = (rx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_rdy   = ~rx_full & grst;
    assign rx_push  = fsl.rx_vld_i & rx_rdy;
    // No bypass: a word pushed this cycle is not visible to a GET until the next.
    assign rx_pop   = fsl.core_get_i & ~rx_empty;
    assign rx_head  = rx_mem[rx_rd_q];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CntOne;
            2'b01:   rx_cnt_d = rx_cnt_q - CntOne;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + PtrOne;
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + PtrOne;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= {fsl.rx_ctl_i, fsl.rx_dat_i};
        end
    end

    assign fsl.rx_rdy_o = rx_rdy;

    // ------------------------------------------------------------------
    // Core response: GET data, non-blocking failure flag, stall
    // ------------------------------------------------------------------
    logic [31:0] core_dat_q;
    logic [31:0] core_dat_d;
    logic        fail_q;
    logic        fail_d;

    always_comb begin
        core_dat_d = core_dat_q;
        fail_d     = fail_q;
        if (fsl.core_put_i) begin
            if (!tx_full) begin
                fail_d = 1'b0;
            end else if (!fsl.core_blk_i) begin
                fail_d = 1'b1;
            end
        end else if (fsl.core_get_i) begin
            if (!rx_empty) begin
                core_dat_d = rx_head[31:0];
                fail_d     = 1'b0;
            end else if (!fsl.core_blk_i) begin
                fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            core_dat_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            core_dat_q <= core_dat_d;
            fail_q     <= fail_d;
        end
    end

`ifdef AEXM_FSL_CTLCHK_EN
    logic ctlerr_q;
    logic ctlerr_d;

    // Only an accepted GET updates the flag; the word is popped even on mismatch.
    always_comb begin
        ctlerr_d = ctlerr_q;
        if (!fsl.core_put_i && rx_pop) begin
            ctlerr_d = rx_head[32] ^ fsl.core_ctl_i;
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            ctlerr_q <= 1'b0;
        end else begin
            ctlerr_q <= ctlerr_d;
        end
    end

    assign fsl.core_ctlerr_o = ctlerr_q;
`else
    logic rx_head_ctl_unused;
    assign rx_head_ctl_unused = rx_head[32];
    assign fsl.core_ctlerr_o  = 1'b0;
`endif

    assign fsl.core_dat_o   = core_dat_q;
    assign fsl.core_fail_o  = fail_q;
    assign fsl.core_stall_o = grst &
                              ((fsl.core_put_i & fsl.core_blk_i & tx_full) |
                               (fsl.core_get_i & fsl.core_blk_i & rx_empty));

endmodule

// File: tb/tb_aexm_fsl_link.sv
// Self-checking bench for aexm_fsl_link: TX/RX scoreboards queued at stimulus time and
// compared as the link delivers words on the external TX port or on core_dat_o.
module tb_aexm_fsl_link;

    logic gclk = 1'b0;
    logic grst;

    int unsigned cmp_cnt = 0;
    int unsigned err_cnt = 0;

    logic [32:0] tx_q[$];
    logic [32:0] rx_q[$];
    logic [31:0] exp_dat = '0;
    logic        exp_ctlerr = 1'b0;

`ifdef AEXM_FSL_CTLCHK_EN
    localparam logic CtlChk = 1'b1;
`else
    localparam logic CtlChk = 1'b0;
`endif

    aexm_fsl_link_if fsl ();

    aexm_fsl_link #(.AW(2)) dut (
        .gclk (gclk),
        .grst (grst),
        .fsl  (fsl)
    );

    always #5 gclk = ~gclk;

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    task automatic idle();
        fsl.core_put_i = 1'b0;
        fsl.core_get_i = 1'b0;
        fsl.core_blk_i = 1'b0;
        fsl.core_ctl_i = 1'b0;
        fsl.core_dat_i = '0;
        fsl.tx_rdy_i   = 1'b0;
        fsl.rx_dat_i   = '0;
        fsl.rx_ctl_i   = 1'b0;
        fsl.rx_vld_i   = 1'b0;
    endtask

    // Drain the TX FIFO, comparing every popped word with the scoreboard.
    task automatic drain_tx();
        logic [32:0] ent;
        step();
        fsl.tx_rdy_i = 1'b1;
        for (int c = 0; c < 32 && tx_q.size() > 0; c++) begin
            @(negedge gclk);
            if (fsl.tx_vld_o) begin
                ent = tx_q.pop_front();
                cmp_cnt++;
                if ({fsl.tx_ctl_o, fsl.tx_dat_o} !== ent) begin
                    err_cnt++;
                    $display("FAIL drain_word: got %h want %h", {fsl.tx_ctl_o, fsl.tx_dat_o}, ent);
                end
            end
        end
        cmp_cnt++;
        if (tx_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain_timeout: %0d words left, want 0", tx_q.size());
            tx_q.delete();
        end
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.tx_vld_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL drain_empty: tx_vld got %b want 0", fsl.tx_vld_o);
        end
        fsl.tx_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge gclk);
        cmp_cnt++;
        if ({fsl.tx_vld_o, fsl.rx_rdy_o, fsl.core_stall_o} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rst_flags: got %b want 000", {fsl.tx_vld_o, fsl.rx_rdy_o, fsl.core_stall_o});
        end
        cmp_cnt++;
        if ({fsl.core_dat_o, fsl.core_fail_o, fsl.core_ctlerr_o} !== 34'h0) begin
            err_cnt++;
            $display("FAIL rst_resp: got dat %h fail %b ctlerr %b want 0", fsl.core_dat_o,
                     fsl.core_fail_o, fsl.core_ctlerr_o);
        end
        step();
        grst = 1'b1;
        @(negedge gclk);
        cmp_cnt++;
        if ({fsl.rx_rdy_o, fsl.tx_vld_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL rst_release: rx_rdy/tx_vld got %b want 10", {fsl.rx_rdy_o, fsl.tx_vld_o});
        end
    endtask

    task automatic test_put_basic();
        step();
        fsl.core_put_i = 1'b1;
        fsl.core_blk_i = 1'b1;
        fsl.core_ctl_i = 1'b1;
        fsl.core_dat_i = 32'h1122_3344;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL put1_stall: got %b want 0", fsl.core_stall_o);
        end
        tx_q.push_back({1'b1, 32'h1122_3344});
        step();
        fsl.core_put_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.tx_vld_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL put1_vld: got %b want 1", fsl.tx_vld_o);
        end
        cmp_cnt++;
        if ({fsl.tx_ctl_o, fsl.tx_dat_o} !== tx_q[0]) begin
            err_cnt++;
            $display("FAIL put1_head: got %h want %h", {fsl.tx_ctl_o, fsl.tx_dat_o}, tx_q[0]);
        end
        cmp_cnt++;
        if (fsl.core_fail_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL put1_fail: got %b want 0", fsl.core_fail_o);
        end
        drain_tx();
    endtask

    task automatic fill_tx();
        for (int i = 0; i < 4; i++) begin
            fsl.core_put_i = 1'b1;
            fsl.core_blk_i = 1'b1;
            fsl.core_ctl_i = i[0];
            fsl.core_dat_i = 32'hA000_0000 + 32'(i);
            @(negedge gclk);
            cmp_cnt++;
            if (fsl.core_stall_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL fill_stall%0d: got %b want 0", i, fsl.core_stall_o);
            end
            tx_q.push_back({fsl.core_ctl_i, fsl.core_dat_i});
            step();
        end
    endtask

    task automatic test_tx_full_stall();
        logic [32:0] ent;
        step();
        fill_tx();
        fsl.core_ctl_i = 1'b1;
        fsl.core_dat_i = 32'hBEEF_0005;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_stall: got %b want 1", fsl.core_stall_o);
        end
        step();
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_retry: got %b want 1", fsl.core_stall_o);
        end
        // Pop one head; the stall must still hold this cycle (full is registered).
        fsl.tx_rdy_i = 1'b1;
        ent = tx_q.pop_front();
        cmp_cnt++;
        if ({fsl.tx_ctl_o, fsl.tx_dat_o} !== ent) begin
            err_cnt++;
            $display("FAIL full_pop: got %h want %h", {fsl.tx_ctl_o, fsl.tx_dat_o}, ent);
        end
        step();
        fsl.tx_rdy_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_release: got %b want 0", fsl.core_stall_o);
        end
        tx_q.push_back({1'b1, 32'hBEEF_0005});
        step();
        fsl.core_put_i = 1'b0;
        drain_tx();
    endtask

    task automatic test_nput_full();
        step();
        fill_tx();
        fsl.core_blk_i = 1'b0;
        fsl.core_dat_i = 32'hDEAD_0099;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL nput_stall: got %b want 0", fsl.core_stall_o);
        end
        step();
        fsl.core_put_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_fail_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL nput_fail: got %b want 1", fsl.core_fail_o);
        end
        drain_tx();
    endtask

    task automatic test_get_basic();
        logic [32:0] ent;
        step();
        // External word and blocking GET in the same cycle: no bypass, GET stalls.
        fsl.rx_vld_i   = 1'b1;
        fsl.rx_dat_i   = 32'hCAFE_F00D;
        fsl.rx_ctl_i   = 1'b0;
        fsl.core_get_i = 1'b1;
        fsl.core_blk_i = 1'b1;
        fsl.core_ctl_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL get_nobypass: stall got %b want 1", fsl.core_stall_o);
        end
        cmp_cnt++;
        if (fsl.rx_rdy_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL get_rdy: got %b want 1", fsl.rx_rdy_o);
        end
        rx_q.push_back({fsl.rx_ctl_i, fsl.rx_dat_i});
        step();
        fsl.rx_vld_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL get_release: stall got %b want 0", fsl.core_stall_o);
        end
        ent = rx_q.pop_front();
        exp_dat = ent[31:0];
        step();
        fsl.core_get_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_dat_o !== exp_dat) begin
            err_cnt++;
            $display("FAIL get_dat: got %h want %h", fsl.core_dat_o, exp_dat);
        end
        cmp_cnt++;
        if ({fsl.core_fail_o, fsl.core_ctlerr_o} !== 2'b00) begin
            err_cnt++;
            $display("FAIL get_flags: fail/ctlerr got %b want 00",
                     {fsl.core_fail_o, fsl.core_ctlerr_o});
        end
    endtask

    task automatic test_nget_empty();
        step();
        fsl.core_get_i = 1'b1;
        fsl.core_blk_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL nget_stall: got %b want 0", fsl.core_stall_o);
        end
        step();
        fsl.core_get_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_fail_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL nget_fail: got %b want 1", fsl.core_fail_o);
        end
        cmp_cnt++;
        if (fsl.core_dat_o !== exp_dat) begin
            err_cnt++;
            $display("FAIL nget_dat: got %h want %h", fsl.core_dat_o, exp_dat);
        end
    endtask

    // One RX word with control bit rctl, then a blocking GET expecting gctl.
    task automatic rx_then_get(input logic [31:0] dat, input logic rctl, input logic gctl);
        logic [32:0] ent;
        step();
        fsl.rx_vld_i = 1'b1;
        fsl.rx_dat_i = dat;
        fsl.rx_ctl_i = rctl;
        @(negedge gclk);
        rx_q.push_back({rctl, dat});
        step();
        fsl.rx_vld_i   = 1'b0;
        fsl.core_get_i = 1'b1;
        fsl.core_blk_i = 1'b1;
        fsl.core_ctl_i = gctl;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL rxget_stall: got %b want 0", fsl.core_stall_o);
        end
        ent = rx_q.pop_front();
        exp_dat = ent[31:0];
        exp_ctlerr = CtlChk & (ent[32] ^ gctl);
        step();
        fsl.core_get_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_dat_o !== exp_dat) begin
            err_cnt++;
            $display("FAIL rxget_dat: got %h want %h", fsl.core_dat_o, exp_dat);
        end
        cmp_cnt++;
        if (fsl.core_ctlerr_o !== exp_ctlerr) begin
            err_cnt++;
            $display("FAIL rxget_ctlerr: got %b want %b", fsl.core_ctlerr_o, exp_ctlerr);
        end
    endtask

    task automatic test_ctlchk();
        rx_then_get(32'h5A5A_0001, 1'b1, 1'b0);
        // Failed non-blocking GET must leave the control-error flag alone.
        step();
        fsl.core_get_i = 1'b1;
        fsl.core_blk_i = 1'b0;
        step();
        fsl.core_get_i = 1'b0;
        @(negedge gclk);
        cmp_cnt++;
        if ({fsl.core_fail_o, fsl.core_ctlerr_o} !== {1'b1, exp_ctlerr}) begin
            err_cnt++;
            $display("FAIL ctl_nget: fail/ctlerr got %b want %b",
                     {fsl.core_fail_o, fsl.core_ctlerr_o}, {1'b1, exp_ctlerr});
        end
        rx_then_get(32'h5A5A_0002, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [32:0] ent;
        logic        got;
        logic        exp_rdy;
        int unsigned k = 0;
        step();
        fsl.rx_vld_i = 1'b1;
        fsl.rx_ctl_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fsl.rx_dat_i = 32'h0B0B_0000 + k;
            @(negedge gclk);
            cmp_cnt++;
            if (fsl.rx_rdy_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_fill%0d: rx_rdy got %b want 1", i, fsl.rx_rdy_o);
            end
            rx_q.push_back({1'b0, fsl.rx_dat_i});
            k++;
            step();
        end
        fsl.rx_dat_i   = 32'h0B0B_0000 + k;
        fsl.core_get_i = 1'b1;
        fsl.core_blk_i = 1'b1;
        fsl.core_ctl_i = 1'b0;
        got = 1'b0;
        // GET held every cycle while the source keeps offering words.
        for (int j = 0; j < 6; j++) begin
            @(negedge gclk);
            if (got) begin
                cmp_cnt++;
                if (fsl.core_dat_o !== exp_dat) begin
                    err_cnt++;
                    $display("FAIL b2b_dat%0d: got %h want %h", j, fsl.core_dat_o, exp_dat);
                end
            end
            exp_rdy = (rx_q.size() < 4);
            cmp_cnt++;
            if (fsl.rx_rdy_o !== exp_rdy) begin
                err_cnt++;
                $display("FAIL b2b_rdy%0d: got %b want %b", j, fsl.rx_rdy_o, exp_rdy);
            end
            cmp_cnt++;
            if (fsl.core_stall_o !== (rx_q.size() == 0)) begin
                err_cnt++;
                $display("FAIL b2b_stall%0d: got %b want %b", j, fsl.core_stall_o,
                         rx_q.size() == 0);
            end
            got = 1'b0;
            if (rx_q.size() > 0) begin
                ent = rx_q.pop_front();
                exp_dat = ent[31:0];
                got = 1'b1;
            end
            if (exp_rdy) begin
                rx_q.push_back({1'b0, fsl.rx_dat_i});
                k++;
            end
            step();
            fsl.rx_dat_i = 32'h0B0B_0000 + k;
        end
        fsl.core_get_i = 1'b0;
        fsl.rx_vld_i   = 1'b0;
        for (int c = 0; c < 8 && rx_q.size() > 0; c++) begin
            step();
            fsl.core_get_i = 1'b1;
            @(negedge gclk);
            cmp_cnt++;
            if (fsl.core_stall_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_drain_stall: got %b want 0", fsl.core_stall_o);
            end
            ent = rx_q.pop_front();
            exp_dat = ent[31:0];
            step();
            fsl.core_get_i = 1'b0;
            @(negedge gclk);
            cmp_cnt++;
            if (fsl.core_dat_o !== exp_dat) begin
                err_cnt++;
                $display("FAIL b2b_drain_dat: got %h want %h", fsl.core_dat_o, exp_dat);
            end
        end
        test_nget_empty();
    endtask

    task automatic test_reset_mid_stall();
        step();
        fill_tx();
        fsl.core_put_i = 1'b0;
        fsl.core_get_i = 1'b1;
        fsl.core_blk_i = 1'b1;
        @(negedge gclk);
        cmp_cnt++;
        if (fsl.core_stall_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_stall: got %b want 1", fsl.core_stall_o);
        end
        grst = 1'b0;
        #1;
        cmp_cnt++;
        if ({fsl.core_stall_o, fsl.tx_vld_o, fsl.rx_rdy_o} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rstmid_flags: stall/tx_vld/rx_rdy got %b want 000",
                     {fsl.core_stall_o, fsl.tx_vld_o, fsl.rx_rdy_o});
        end
        cmp_cnt++;
        if ({fsl.core_dat_o, fsl.core_fail_o} !== 33'h0) begin
            err_cnt++;
            $display("FAIL rstmid_resp: dat %h fail %b want 0", fsl.core_dat_o, fsl.core_fail_o);
        end
        fsl.core_get_i = 1'b0;
        tx_q.delete();
        rx_q.delete();
        exp_dat = '0;
        exp_ctlerr = 1'b0;
        step();
        step();
        grst = 1'b1;
        @(negedge gclk);
        cmp_cnt++;
        if ({fsl.rx_rdy_o, fsl.tx_vld_o, fsl.core_stall_o} !== 3'b100) begin
            err_cnt++;
            $display("FAIL rstmid_release: rx_rdy/tx_vld/stall got %b want 100",
                     {fsl.rx_rdy_o, fsl.tx_vld_o, fsl.core_stall_o});
        end
        test_nget_empty();
        rx_then_get(32'h600D_D00D, 1'b0, 1'b0);
    endtask

    initial begin
        idle();
        grst = 1'b1;
        #2;
        grst = 1'b0;
        test_reset();
        test_put_basic();
        test_tx_full_stall();
        test_nput_full();
        test_get_basic();
        test_nget_empty();
        test_ctlchk();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
